// File: rtl/mux_nx1_stream.sv
// N:1 stream multiplexer with a single registered output stage.
// Selects a channel either explicitly (sel) or by round-robin among valid channels.
module mux_nx1_stream #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Handshake: a beat moves on a rising edge where valid && ready are both high.
    // A producer holds valid and data stable until it sees ready; valid never
    // depends on ready. in_ready may depend on in_valid (round-robin mode).

    logic [WIDTH-1:0] chan_data [N_IN];
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] cand;
    logic             grant_valid;
    logic             can_accept;
    logic             xfer;
    int               rr_idx;

    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign can_accept = !out_valid || out_ready;

    // Round-robin scans offsets from the highest down so the channel nearest
    // rr_ptr is the last one written and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        rr_idx      = 0;
        cand        = '0;
        if (!mode) begin
            if (int'(sel) < N_IN) begin
                grant_valid = 1'b1;
                grant       = sel;
            end
        end else begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                rr_idx = int'(rr_ptr) + k;
                if (rr_idx >= N_IN) begin
                    rr_idx = rr_idx - N_IN;
                end
                cand = SEL_W'(rr_idx);
                if (in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant       = cand;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant_valid && can_accept) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = grant_valid && can_accept && in_valid[grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= chan_data[grant];
                out_chan  <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Pointer moves past the granted channel so it gets lowest priority next.
            if (xfer && mode) begin
                rr_ptr <= (grant == SEL_W'(N_IN - 1)) ? '0 : grant + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream (WIDTH=8, N_IN=4): explicit select,
// backpressure, round-robin wrap and sparse grants, drain and mid-stream reset.
module tb_mux_nx1_stream;

    localparam int WIDTH = 8;
    localparam int N_IN  = 4;

    logic                  clk;
    logic                  rst;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic                  mode;
    logic [1:0]            sel;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_chan;
    logic                  out_valid;
    logic                  out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected beats leaving the output stage: {chan, data}
    logic [9:0] exp_q[$];

    mux_nx1_stream #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        #1;
    endtask

    task automatic expect_beat(input logic [1:0] c, input logic [7:0] d);
        exp_q.push_back({c, d});
    endtask

    // scoreboard: a beat drains at the edge following a negedge with valid && ready
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", {22'd0, out_chan, out_data}, 32'h3ff);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("sb_beat", {22'd0, out_chan, out_data}, {22'd0, e});
            end
        end
    end

    initial begin
        logic [1:0] rr_seq [6];
        logic [7:0] rr_dat [4];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_dat = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_out_chan", out_chan, 0);
        tick();
        rst = 1'b0;

        // explicit select
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        drive(1'b0, 2'd2, 4'hF, 1'b1);
        check("sel2_in_ready", in_ready, 4'b0100);
        expect_beat(2'd2, 8'h33);
        tick();
        check("sel2_out_valid", out_valid, 1);
        check("sel2_out_data", out_data, 8'h33);
        check("sel2_out_chan", out_chan, 2);
        drive(1'b0, 2'd3, 4'hF, 1'b1);
        check("sel3_in_ready", in_ready, 4'b1000);
        expect_beat(2'd3, 8'h44);
        tick();
        check("sel3_out_data", out_data, 8'h44);
        check("sel3_out_chan", out_chan, 3);

        // backpressure
        in_data = {8'h44, 8'h33, 8'h22, 8'h5A};
        drive(1'b0, 2'd0, 4'b0001, 1'b1);
        expect_beat(2'd0, 8'h5A);
        tick();
        check("bp_load_data", out_data, 8'h5A);
        drive(1'b0, 2'd0, 4'hF, 1'b0);
        check("bp_in_ready_blocked", in_ready, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 8'h5A);
            check("bp_hold_chan", out_chan, 0);
            check("bp_hold_in_ready", in_ready, 4'b0000);
        end
        in_data = {8'h44, 8'h33, 8'hA5, 8'h5A};
        drive(1'b0, 2'd1, 4'b0010, 1'b1);
        check("bp_release_in_ready", in_ready, 4'b0010);
        expect_beat(2'd1, 8'hA5);
        tick();
        check("bp_refill_valid", out_valid, 1);
        check("bp_refill_data", out_data, 8'hA5);
        check("bp_refill_chan", out_chan, 1);

        // idle drain
        drive(1'b0, 2'd1, 4'b0000, 1'b1);
        tick();
        check("drain_out_valid", out_valid, 0);
        check("drain_keep_data", out_data, 8'hA5);
        check("drain_keep_chan", out_chan, 1);

        // round-robin wrap, all channels valid
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'd0, 4'hF, 1'b1);
            check("rr_in_ready", in_ready, 4'b0001 << rr_seq[i]);
            expect_beat(rr_seq[i], rr_dat[rr_seq[i]]);
            tick();
            check("rr_out_chan", out_chan, rr_seq[i]);
            check("rr_out_data", out_data, rr_dat[rr_seq[i]]);
        end

        // sparse round-robin: rr_ptr is now 2, only ch1/ch3 valid
        drive(1'b1, 2'd0, 4'b1010, 1'b1);
        check("sparse1_in_ready", in_ready, 4'b1000);
        expect_beat(2'd3, 8'h44);
        tick();
        check("sparse1_chan", out_chan, 3);
        check("sparse2_in_ready", in_ready, 4'b0010);
        expect_beat(2'd1, 8'h22);
        tick();
        check("sparse2_chan", out_chan, 1);
        check("sparse3_in_ready", in_ready, 4'b1000);
        expect_beat(2'd3, 8'h44);
        tick();
        check("sparse3_chan", out_chan, 3);
        check("sparse3_data", out_data, 8'h44);
        drive(1'b1, 2'd0, 4'b0000, 1'b1);
        tick();
        check("sparse_drain_valid", out_valid, 0);

        // mid-stream reset: load a beat (ptr moves 0 -> 1), hold it, then reset
        drive(1'b1, 2'd0, 4'hF, 1'b0);
        tick();
        drive(1'b1, 2'd0, 4'b0000, 1'b0);
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_data", out_data, 8'h11);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_data", out_data, 8'h00);
        check("async_reset_chan", out_chan, 0);
        tick();
        rst = 1'b0;
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        check("post_reset_in_ready", in_ready, 4'b0001);
        expect_beat(2'd0, 8'h11);
        tick();
        check("post_reset_valid", out_valid, 1);
        check("post_reset_chan", out_chan, 0);
        check("post_reset_data", out_data, 8'h11);
        drive(1'b1, 2'd0, 4'b0000, 1'b1);
        tick();
        check("final_drain_valid", out_valid, 0);
        tick();

        check("sb_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
- Parametrised successor to the team's 2:1 gate-level mux.
- Selects one of N_IN input channels of WIDTH bits and forwards it through a single registered output stage using valid/ready handshakes.
- Two selection modes: explicit select (sel port) and round-robin arbitration among valid channels.
- Sits between multiple producers and one consumer in the datapath. Throughput is one beat per cycle.

Parameters:
- WIDTH, 8, data bits per channel.
- N_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(N_IN), select/channel-index width (derived localparam, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready (combinational).
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  channel index, used only when mode=0.
- out_data  out  WIDTH  registered data.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. Reset mid-transfer discards the held beat.
- Reset release: first acceptance is possible at the first rising edge after rst deasserts.
- can_accept = !out_valid || out_ready. The stage accepts a new beat in the same cycle the held beat drains, giving full throughput.
- Grant, mode=0:
  - grant = sel when sel < N_IN.
  - sel >= N_IN means no grant; all in_ready=0.
- Grant, mode=1:
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... wrapping modulo N_IN.
  - No valid channel means no grant.
- in_ready[grant] = can_accept; all other in_ready bits = 0.
  - In mode 1, in_ready depends on in_valid. This is permitted; producers must not make in_valid depend on in_ready.
- Transfer on channel g: in_valid[g] && in_ready[g] at a rising edge.
  - Next cycle: out_data = in_data[g], out_chan = g, out_valid = 1.
  - Latency is 1 cycle, input to output.
- Hold: while out_valid && !out_ready, out_data/out_chan/out_valid stay stable and no input is accepted.
- Drain without refill: out_valid && out_ready with no transfer clears out_valid to 0 next cycle. out_data and out_chan hold their last values.
- rr_ptr:
  - Updates only on a transfer in mode 1: rr_ptr <= (g == N_IN-1) ? 0 : g+1.
  - Unchanged in mode 0.
- Mode change: takes effect on the next grant evaluation. A beat already held in the output stage is unaffected.
- Fairness (mode 1): with all channels continuously valid and out_ready=1, grants rotate 0,1,...,N_IN-1,0, ...
- No data is duplicated or dropped.

Test Plan:
- WIDTH=8, N_IN=4 for all scenarios.
- 1. Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0x00, out_chan=0 immediately, before any clk edge. After release, the first accepted beat appears 1 cycle later.
- 2. Explicit select: mode=0, sel=2, in_data ch0..ch3 = 0x11,0x22,0x33,0x44, all valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x33, out_chan=2. With sel=3 (the last channel, still < N_IN), out_data=0x44, out_chan=3.
- 3. Backpressure: out_ready=0 for 3 cycles after a beat 0x5A -> out_data holds 0x5A, all in_ready=0. Raise out_ready with ch1 valid 0xA5 -> 0x5A drains and 0xA5 loads in the same edge; out_valid stays 1.
- 4. Round-robin wrap: mode=1, all channels valid, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1.
- 5. Sparse round-robin: mode=1, only ch1 and ch3 valid, rr_ptr=2 -> grant ch3, then ch1, then ch3. ch0 and ch2 in_ready are always 0.
- 6. Idle/drain: all in_valid=0, out_ready=1 with a held beat -> out_valid goes 0 the next cycle, and out_data keeps its last value.
